mem_bus_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between instruction fetch (IF) and data access (MEM stage).

---
 rtl/mem_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port SRAM between fetch and data access.
// Fixed-latency sequencer with registered acks and a combinational stall vector.
module mem_bus_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [DATA_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [5:0]        stall_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              grant_dm;
  logic              in_acc;

  // state and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  // arbitration, access sequencing and completion
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    grant_dm   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // data wins a tie unless it also won the previous grant
        grant_dm = dm_req_i & (~if_req_i | ~last_q);
        if (dm_req_i | if_req_i) begin
          owner_d = grant_dm;
          last_d  = grant_dm;
          cnt_d   = CNT_LOAD;
          state_d = S_ACC;
          if (grant_dm) begin
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            sel_d   = dm_sel_i;
            wdata_d = dm_wdata_i;
          end else begin
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            wdata_d = '0;
          end
        end
      end
      S_ACC: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (owner_q) begin
            dm_ack_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // SRAM drive is active only while accessing
  always_comb begin
    in_acc      = (state_q == S_ACC);
    mem_ce_o    = in_acc;
    mem_we_o    = in_acc & we_q;
    mem_sel_o   = in_acc ? sel_q : 4'h0;
    mem_addr_o  = in_acc ? addr_q : '0;
    mem_wdata_o = in_acc ? wdata_q : '0;
  end

  // freeze the pipeline while a request waits for its ack
  always_comb begin
    stall_o = 6'b000000;
    if (dm_req_i & ~dm_ack_q)      stall_o = 6'b011111;
    else if (if_req_i & ~if_ack_q) stall_o = 6'b000011;
  end

  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign if_ack_o   = if_ack_q;
  assign dm_ack_o   = dm_ack_q;

  // owner must hold its request for the whole access
  a_hold_req: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_ACC) |-> (owner_q ? dm_req_i : if_req_i));

  a_one_ack: assert property (@(posedge clk) disable iff (rst)
    !(if_ack_q && dm_ack_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, latency and reset.
// Instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   prev_ack;

  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata;
  logic [31:0] a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_dm_sel, a_mem_sel;
  logic        a_mem_ce, a_mem_we;
  logic [5:0]  a_stall;

  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata;
  logic [31:0] b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dm_sel, b_mem_sel;
  logic        b_mem_ce, b_mem_we;
  logic [5:0]  b_stall;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr),
    .if_rdata_o(a_if_rdata), .if_ack_o(a_if_ack),
    .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_sel_i(a_dm_sel),
    .dm_addr_i(a_dm_addr), .dm_wdata_i(a_dm_wdata),
    .dm_rdata_o(a_dm_rdata), .dm_ack_o(a_dm_ack),
    .mem_ce_o(a_mem_ce), .mem_we_o(a_mem_we), .mem_sel_o(a_mem_sel),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(a_mem_rdata), .stall_o(a_stall)
  );

  mem_bus_arbiter #(.DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr),
    .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_sel_i(b_dm_sel),
    .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
    .dm_rdata_o(b_dm_rdata), .dm_ack_o(b_dm_ack),
    .mem_ce_o(b_mem_ce), .mem_we_o(b_mem_we), .mem_sel_o(b_mem_sel),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(b_mem_rdata), .stall_o(b_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0;
    a_dm_sel = 0; a_dm_addr = 0; a_dm_wdata = 0; a_mem_rdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0;
    b_dm_sel = 0; b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 0;

    // power-on reset
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_if_ack", {31'd0, a_if_ack}, 0);
    chk("rst_dm_ack", {31'd0, a_dm_ack}, 0);
    chk("rst_ce", {31'd0, a_mem_ce}, 0);
    chk("rst_stall", {26'd0, a_stall}, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_dm_rdata", a_dm_rdata, 0);

    // MEM_LAT=3 data read
    b_dm_req = 1; b_dm_we = 0; b_dm_sel = 4'hF;
    b_dm_addr = 32'h200; b_mem_rdata = 32'h1234_5678;
    #1;
    chk("l3_stall_idle", {26'd0, b_stall}, 32'h1F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l3_ce", {31'd0, b_mem_ce}, 1);
      chk("l3_addr", b_mem_addr, 32'h200);
      chk("l3_we", {31'd0, b_mem_we}, 0);
      chk("l3_no_ack", {31'd0, b_dm_ack}, 0);
    end
    chk("l3_sel", {28'd0, b_mem_sel}, 32'hF);
    chk("l3_wdata", b_mem_wdata, 0);
    tick();
    chk("l3_ack", {31'd0, b_dm_ack}, 1);
    chk("l3_if_ack", {31'd0, b_if_ack}, 0);
    chk("l3_rdata", b_dm_rdata, 32'h1234_5678);
    chk("l3_ce_done", {31'd0, b_mem_ce}, 0);
    chk("l3_stall_ack", {26'd0, b_stall}, 0);
    b_dm_req = 0;
    tick();
    chk("l3_ack_off", {31'd0, b_dm_ack}, 0);
    chk("l3_if_rdata", b_if_rdata, 0);

    // data write on MEM_LAT=1
    a_dm_req = 1; a_dm_we = 1; a_dm_sel = 4'b0011;
    a_dm_addr = 32'h100; a_dm_wdata = 32'hDEAD_BEEF;
    a_mem_rdata = 32'h7777_7777;
    #1;
    chk("wr_stall", {26'd0, a_stall}, 32'h1F);
    tick();
    chk("wr_ce", {31'd0, a_mem_ce}, 1);
    chk("wr_we", {31'd0, a_mem_we}, 1);
    chk("wr_sel", {28'd0, a_mem_sel}, 32'h3);
    chk("wr_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    a_dm_addr = 32'h999;
    #1;
    chk("wr_addr_held", a_mem_addr, 32'h100);
    tick();
    chk("wr_ack", {31'd0, a_dm_ack}, 1);
    chk("wr_rdata_kept", a_dm_rdata, 0);
    chk("wr_ce_done", {31'd0, a_mem_ce}, 0);
    chk("wr_stall_ack", {26'd0, a_stall}, 0);
    a_dm_req = 0; a_dm_we = 0;
    tick();
    chk("wr_ack_off", {31'd0, a_dm_ack}, 0);

    // single fetch on MEM_LAT=1
    a_if_req = 1; a_if_addr = 32'h4; a_mem_rdata = 32'h3401_1100;
    #1;
    chk("if_stall", {26'd0, a_stall}, 32'h3);
    chk("if_ce_idle", {31'd0, a_mem_ce}, 0);
    tick();
    chk("if_ce", {31'd0, a_mem_ce}, 1);
    chk("if_addr", a_mem_addr, 32'h4);
    chk("if_we", {31'd0, a_mem_we}, 0);
    chk("if_sel", {28'd0, a_mem_sel}, 32'hF);
    chk("if_stall_acc", {26'd0, a_stall}, 32'h3);
    tick();
    chk("if_ack", {31'd0, a_if_ack}, 1);
    chk("if_rdata", a_if_rdata, 32'h3401_1100);
    chk("if_ce_done", {31'd0, a_mem_ce}, 0);
    chk("if_stall_ack", {26'd0, a_stall}, 0);
    a_if_req = 0;
    tick();
    chk("if_ack_off", {31'd0, a_if_ack}, 0);

    // both requesting: DM, IF, DM, IF
    a_if_req = 1; a_if_addr = 32'h40;
    a_dm_req = 1; a_dm_we = 0; a_dm_sel = 4'hF; a_dm_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      a_mem_rdata = 32'hA000_0000 + i;
      #1;
      chk("arb_idle_ce", {31'd0, a_mem_ce}, 0);
      tick();
      chk("arb_ce", {31'd0, a_mem_ce}, 1);
      chk("arb_addr", a_mem_addr, (i % 2 == 0) ? 32'h80 : 32'h40);
      tick();
      chk("arb_dm_ack", {31'd0, a_dm_ack}, (i % 2 == 0) ? 1 : 0);
      chk("arb_if_ack", {31'd0, a_if_ack}, (i % 2 == 0) ? 0 : 1);
      chk("arb_done_ce", {31'd0, a_mem_ce}, 0);
      if (i % 2 == 0) chk("arb_dm_rd", a_dm_rdata, 32'hA000_0000 + i);
      else            chk("arb_if_rd", a_if_rdata, 32'hA000_0000 + i);
      tick();
      chk("arb_no_grant", {31'd0, a_mem_ce}, 0);
    end
    a_if_req = 0; a_dm_req = 0;
    tick();

    // back-to-back fetches, one every 3 cycles
    a_if_req = 1; a_if_addr = 32'h10; a_mem_rdata = 32'h5555_0000;
    prev_ack = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      a_if_addr = 32'h10 + 4 * (k + 1);
      #1;
      chk("b2b_addr", a_mem_addr, 32'h10 + 4 * k);
      tick();
      chk("b2b_ack", {31'd0, a_if_ack}, 1);
      if (k > 0) chk("b2b_period", cyc - prev_ack, 3);
      prev_ack = cyc;
      a_if_req = 0;
      tick();
      a_if_req = 1;
    end
    a_if_req = 0;
    tick();

    // reset during a data read
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h300;
    a_mem_rdata = 32'h55;
    tick();
    chk("mr_ce", {31'd0, a_mem_ce}, 1);
    rst = 1; a_dm_req = 0;
    tick();
    chk("mr_ce0", {31'd0, a_mem_ce}, 0);
    chk("mr_ack", {31'd0, a_dm_ack}, 0);
    chk("mr_dm_rdata", a_dm_rdata, 0);
    chk("mr_if_rdata", a_if_rdata, 0);
    chk("mr_addr", a_mem_addr, 0);
    chk("mr_stall", {26'd0, a_stall}, 0);
    tick();
    rst = 0;
    tick();
    chk("mr_ack_after", {31'd0, a_dm_ack}, 0);
    chk("mr_ce_after", {31'd0, a_mem_ce}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
